// File: rtl/dsp_out_accumulator_if.sv
// Handshake bundle between the DSP product stream, the batch accumulator and
// the result consumer.
interface dsp_out_accumulator_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  out_valid;
  logic [ACC_WIDTH-1:0]  out_data;
  logic [2:0]            out_cnt;
  logic                  out_ovf;
  logic                  out_ready;
  logic                  drop;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_ovf, drop
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_ovf, drop
  );
endinterface

// File: rtl/dsp_out_accumulator.sv
// Sums batches of unsigned DSP products with saturation and presents each
// batch result on a valid/ready output register.
module dsp_out_accumulator #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int COUNT      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dsp_out_accumulator_if.slave bus
);

  logic [ACC_WIDTH-1:0] acc;
  logic [2:0]           cnt;
  logic                 sat;

  logic [ACC_WIDTH:0]   sum;
  logic                 sat_now;
  logic [ACC_WIDTH-1:0] clamped;
  logic                 accept;
  logic                 batch_end;

  assign bus.in_ready = !bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign batch_end    = accept & ((cnt == 3'(COUNT - 1)) | bus.in_last);

  // One extra bit of headroom exposes the carry used for saturation.
  assign sum     = {1'b0, acc} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, bus.in_data};
  assign sat_now = sum[ACC_WIDTH];
  assign clamped = sat_now ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      cnt           <= '0;
      sat           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_cnt   <= '0;
      bus.out_ovf   <= 1'b0;
      bus.drop      <= 1'b0;
    end else begin
      if (bus.in_valid & !bus.in_ready)
        bus.drop <= 1'b1;

      if (batch_end) begin
        bus.out_data <= clamped;
        bus.out_cnt  <= cnt + 3'd1;
        bus.out_ovf  <= sat | sat_now;
        acc          <= '0;
        cnt          <= '0;
        sat          <= 1'b0;
      end else if (accept) begin
        acc <= clamped;
        cnt <= cnt + 3'd1;
        sat <= sat | sat_now;
      end

      // A new result on the handshake edge keeps out_valid high with no bubble.
      if (batch_end)
        bus.out_valid <= 1'b1;
      else if (bus.out_ready)
        bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsp_out_accumulator.sv
// Directed bench for dsp_out_accumulator: default-width instance plus a
// narrow-accumulator instance for saturation.
module tb_dsp_out_accumulator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  dsp_out_accumulator_if #(.DATA_WIDTH(4), .ACC_WIDTH(8)) bus_a ();
  dsp_out_accumulator_if #(.DATA_WIDTH(4), .ACC_WIDTH(5)) bus_b ();

  dsp_out_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8), .COUNT(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  dsp_out_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(5), .COUNT(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [3:0] d, input logic l);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_last  = l;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] d);
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = d;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    check("in_ready_in_reset", bus_a.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out_data", bus_a.out_data, 0);
    check("rst_out_cnt", bus_a.out_cnt, 0);
    check("rst_out_ovf", bus_a.out_ovf, 0);
    check("rst_drop", bus_a.drop, 0);
    idle(1);

    // Full batch 3,5,7,9
    send_a(4'd3, 1'b0);
    send_a(4'd5, 1'b0);
    send_a(4'd7, 1'b0);
    check("full_not_yet_valid", bus_a.out_valid, 0);
    send_a(4'd9, 1'b0);
    check("full_valid", bus_a.out_valid, 1);
    check("full_data", bus_a.out_data, 24);
    check("full_cnt", bus_a.out_cnt, 4);
    check("full_ovf", bus_a.out_ovf, 0);
    check("full_drop", bus_a.drop, 0);
    idle(1);
    check("full_taken", bus_a.out_valid, 0);
    check("full_data_hold", bus_a.out_data, 24);

    // Early end by in_last, then a clean batch
    send_a(4'd4, 1'b0);
    send_a(4'd6, 1'b1);
    check("last_valid", bus_a.out_valid, 1);
    check("last_data", bus_a.out_data, 10);
    check("last_cnt", bus_a.out_cnt, 2);
    send_a(4'd1, 1'b0);
    check("handshake_with_accum", bus_a.out_valid, 0);
    send_a(4'd1, 1'b0);
    send_a(4'd1, 1'b0);
    send_a(4'd1, 1'b0);
    check("cleared_acc_data", bus_a.out_data, 4);
    check("cleared_acc_cnt", bus_a.out_cnt, 4);

    // Back-to-back full batches
    for (int i = 0; i < 4; i++) send_a(4'd2, 1'b0);
    check("b2b_first_valid", bus_a.out_valid, 1);
    check("b2b_first_data", bus_a.out_data, 8);
    for (int i = 0; i < 4; i++) send_a(4'd3, 1'b0);
    check("b2b_second_valid", bus_a.out_valid, 1);
    check("b2b_second_data", bus_a.out_data, 12);

    // Single-sample batches: handshake and batch end on the same edge
    send_a(4'd5, 1'b1);
    send_a(4'd6, 1'b1);
    check("nobubble_valid", bus_a.out_valid, 1);
    check("nobubble_data", bus_a.out_data, 6);
    check("nobubble_cnt", bus_a.out_cnt, 1);
    idle(1);

    // Stall with offered samples
    bus_a.out_ready = 1'b0;
    send_a(4'd1, 1'b0);
    send_a(4'd2, 1'b1);
    check("stall_valid", bus_a.out_valid, 1);
    check("stall_in_ready", bus_a.in_ready, 0);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_in_ready_hold", bus_a.in_ready, 0);
      check("stall_data_hold", bus_a.out_data, 3);
      check("stall_drop", bus_a.drop, 1);
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    #1;
    check("unstall_in_ready", bus_a.in_ready, 1);
    @(posedge clk); #1;
    check("unstall_valid", bus_a.out_valid, 0);
    check("drop_sticky", bus_a.drop, 1);
    for (int i = 0; i < 4; i++) send_a(4'd4, 1'b0);
    check("frozen_acc_data", bus_a.out_data, 16);
    check("frozen_acc_cnt", bus_a.out_cnt, 4);

    // Reset mid-batch
    send_a(4'd7, 1'b0);
    send_a(4'd7, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", bus_a.out_valid, 0);
    check("midrst_data", bus_a.out_data, 0);
    check("midrst_cnt", bus_a.out_cnt, 0);
    check("midrst_drop", bus_a.drop, 0);
    check("midrst_in_ready", bus_a.in_ready, 1);
    bus_a.in_last = 1'b1;
    @(posedge clk); #1;
    bus_a.in_last = 1'b0;
    check("lone_last_no_effect", bus_a.out_valid, 0);
    send_a(4'd1, 1'b0);
    send_a(4'd2, 1'b0);
    send_a(4'd3, 1'b0);
    send_a(4'd4, 1'b0);
    check("postrst_data", bus_a.out_data, 10);
    check("postrst_cnt", bus_a.out_cnt, 4);
    idle(1);

    // Narrow accumulator saturation
    for (int i = 0; i < 4; i++) send_b(4'd9);
    check("sat_valid", bus_b.out_valid, 1);
    check("sat_data", bus_b.out_data, 31);
    check("sat_ovf", bus_b.out_ovf, 1);
    for (int i = 0; i < 4; i++) send_b(4'd1);
    check("sat_next_data", bus_b.out_data, 4);
    check("sat_next_ovf", bus_b.out_ovf, 0);
    send_b(4'd9);
    send_b(4'd9);
    send_b(4'd9);
    send_b(4'd4);
    check("edge_no_sat_data", bus_b.out_data, 31);
    check("edge_no_sat_ovf", bus_b.out_ovf, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
